trivium_byte_xor: RTL and testbench
===================================

// Module: trivium_byte_xor
// PURPOSE
//   Downstream consumer of the Trivium keystream generator. Drives the core's enable and
//   discards the warm-up bits. Packs the following keystream bits into bytes and XORs each
//   byte with one plaintext/ciphertext byte over valid/ready handshakes.
//   Sits between the keystream core and the byte-wide data path.
// PARAMETERS
//   WARMUP_CYCLES  1152  enable pulses discarded after start before bits are used
//   DATA_W         8     data/keystream word width in bits
// PORTS
//   clk        in   1       clock, rising edge
//   rst        in   1       reset, asynchronous, active-low
//   start      in   1       pulse: begin session (honoured only in IDLE)
//   clear      in   1       synchronous abort: return to IDLE, drop all data
//   ks_enable  out  1       enable to keystream core (one keystream bit per high cycle)
//   ks_bit     in   1       keystream bit from core, registered, valid 1 cycle after ks_enable
//   in_valid   in   1       input byte valid
//   in_ready   out  1       block accepts in_data this cycle
//   in_data    in   DATA_W  plaintext or ciphertext byte
//   out_valid  out  1       out_data valid
//   out_ready  in   1       sink accepts out_data
//   out_data   out  DATA_W  in_data XOR keystream byte
//   busy       out  1       high in any state other than IDLE
// BEHAVIOUR
//   Reset: state=IDLE. ks_enable, in_ready, out_valid and busy are 0. out_data, bit
//     counter and warm-up counter are 0.
//   Key/IV load of the core is done by the system controller before start. This block
//     never resets the core.
//   FSM IDLE -> WARMUP -> FILL -> HOLD -> FILL ...
//     IDLE:   ks_enable=0. If start=1, go to WARMUP and set warm_cnt=0.
//     WARMUP: ks_enable=1 every cycle. Go to FILL after exactly WARMUP_CYCLES high cycles.
//             The bit produced by the last warm-up pulse is discarded.
//     FILL:   ks_enable=1 for exactly DATA_W cycles. pend (ks_enable delayed one cycle)
//             qualifies sampling of ks_bit. The first sampled bit goes to ks_byte[0]
//             (LSB first). Go to HOLD in the cycle the DATA_W-th bit is captured.
//     HOLD:   ks_enable=0. in_ready = !out_valid || out_ready.
//             When in_valid && in_ready: out_data <= in_data ^ ks_byte, out_valid <= 1,
//             then go to FILL. Each keystream byte is used exactly once.
//   Output register: out_valid clears on out_valid && out_ready, unless a new byte is
//     loaded in the same cycle; the new byte wins and out_valid stays 1.
//     Under stall, out_data is stable while out_valid && !out_ready.
//   in_ready is 0 outside HOLD. No keystream bits are generated while in HOLD
//     (back-pressure stops the core).
//   start outside IDLE is ignored.
//   clear has priority over every transition: IDLE next cycle, out_valid=0,
//     counters zeroed. A pending out byte is lost.
//   rst asserted mid-operation: immediate return to reset values. Bits in flight are
//     dropped.
//   Throughput: 1 byte per DATA_W+2 cycles when the sink is always ready.
// STRUCTURE
//   trivium_pkg: WARMUP_CYCLES default constant and state enum
//     {IDLE, WARMUP, FILL, HOLD}.
//   Sub-module ks_byte_packer: shift register plus bit counter. Inputs: sample, bit,
//     flush. Outputs: byte, byte_done.
//   Top level: FSM, warm-up counter ($clog2(WARMUP_CYCLES+1) bits), handshake,
//     output register.
// TESTING
//   1 start in IDLE -> ks_enable high 1152 consecutive cycles, then 8 FILL cycles.
//     No in_ready before FILL completes.
//   2 FILL bits 1,0,1,1,0,0,0,1 with in_data=0xFF -> ks_byte=0x8D, out_data=0x72,
//     out_valid=1.
//   3 Hold out_ready=0 with two input bytes offered -> first out_data stable.
//     Next byte filled, then ks_enable=0 and in_ready=0 until out_ready=1.
//   4 Streaming: in_valid=1, out_ready=1, 16 bytes -> 16 outputs at 10-cycle spacing.
//     Each byte equals in_data XOR the model's keystream byte.
//   5 clear at warm-up cycle 500 -> IDLE next cycle, busy=0.
//     New start restarts the full 1152-cycle warm-up.
//   6 rst low mid-FILL (bit 4) -> all outputs 0 asynchronously. start pulse while busy
//     -> no effect on counters.

Source files
------------

// File: rtl/trivium_byte_xor_pkg.sv
// trivium_byte_xor_pkg: shared constants and FSM state type for the keystream byte XOR block.
package trivium_byte_xor_pkg;
   localparam int WARMUP_DEF = 1152;
   localparam int DATA_W = 8;
   typedef enum logic [1:0] {IDLE, WARMUP, FILL, HOLD} state_t;
endpackage

// File: rtl/trivium_byte_xor_if.sv
// trivium_byte_xor_if: byte-wide valid/ready input and output channels.
interface trivium_byte_xor_if
   import trivium_byte_xor_pkg::*;
();
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
   modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/trivium_byte_xor_ks_byte_packer.sv
// trivium_byte_xor_ks_byte_packer: packs sampled keystream bits LSB first into a byte.
module trivium_byte_xor_ks_byte_packer
   import trivium_byte_xor_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_sample,
   input  logic              i_bit,
   input  logic              i_flush,
   output logic [DATA_W-1:0] o_byte,
   output logic              o_byte_done
);
   localparam int CW = $clog2(DATA_W);
   logic [CW-1:0]     r_cnt;
   logic [DATA_W-1:0] r_byte;
   assign o_byte = r_byte;
   assign o_byte_done = i_sample && r_cnt == CW'(DATA_W - 1);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_cnt  <= '0;
         r_byte <= '0;
      end else if (i_flush) begin
         r_cnt  <= '0;
         r_byte <= '0;
      end else if (i_sample) begin
         r_byte <= {i_bit, r_byte[DATA_W-1:1]};
         r_cnt  <= o_byte_done ? '0 : r_cnt + 1'b1;
      end
endmodule

// File: rtl/trivium_byte_xor.sv
// trivium_byte_xor: drives the keystream core, drops warm-up bits, and XORs
// each packed keystream byte with one input byte over valid/ready handshakes.
module trivium_byte_xor
   import trivium_byte_xor_pkg::*;
#(
   parameter int WARMUP_CYCLES = WARMUP_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_start,
   input  logic i_clear,
   input  logic i_ks_bit,
   output logic o_ks_enable,
   output logic o_busy,
   trivium_byte_xor_if.slave bus
);
   localparam int WW = $clog2(WARMUP_CYCLES + 1);
   localparam int FW = $clog2(DATA_W + 1);
   state_t            r_state;
   logic [WW-1:0]     r_warm_cnt;
   logic [FW-1:0]     r_fill_cnt;
   logic              r_pend;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic [DATA_W-1:0] w_ks_byte;
   logic              w_byte_done;
   logic              w_accept;
   logic              w_fill_en;
   assign w_fill_en = r_state == FILL && r_fill_cnt < FW'(DATA_W);
   assign o_ks_enable = r_state == WARMUP || w_fill_en;
   assign o_busy = r_state != IDLE;
   assign bus.in_ready = r_state == HOLD && (!r_out_valid || bus.out_ready);
   assign bus.out_valid = r_out_valid;
   assign bus.out_data = r_out_data;
   assign w_accept = bus.in_valid && bus.in_ready;
   trivium_byte_xor_ks_byte_packer u_packer (
      .clk         (clk),
      .rst         (rst),
      .i_sample    (r_pend),
      .i_bit       (i_ks_bit),
      .i_flush     (i_clear),
      .o_byte      (w_ks_byte),
      .o_byte_done (w_byte_done)
   );
   // Only fill pulses set pend, so the bit from the last warm-up pulse is never sampled.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_state     <= IDLE;
         r_warm_cnt  <= '0;
         r_fill_cnt  <= '0;
         r_pend      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (i_clear) begin
         r_state     <= IDLE;
         r_warm_cnt  <= '0;
         r_fill_cnt  <= '0;
         r_pend      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_pend      <= w_fill_en;
         r_fill_cnt  <= w_fill_en ? r_fill_cnt + 1'b1 : '0;
         r_out_valid <= w_accept || (r_out_valid && !bus.out_ready);
         if (w_accept) r_out_data <= bus.in_data ^ w_ks_byte;
         unique case (r_state)
            IDLE:
               if (i_start) begin
                  r_state    <= WARMUP;
                  r_warm_cnt <= '0;
               end
            WARMUP:
               if (r_warm_cnt == WW'(WARMUP_CYCLES - 1)) begin
                  r_state    <= FILL;
                  r_warm_cnt <= '0;
               end else r_warm_cnt <= r_warm_cnt + 1'b1;
            FILL: if (w_byte_done) r_state <= HOLD;
            HOLD: if (w_accept) r_state <= FILL;
         endcase
      end
endmodule

// File: tb/tb_trivium_byte_xor.sv
// tb_trivium_byte_xor: random-stimulus bench with a keystream-core stand-in and a
// scoreboard that derives each output byte from the recorded keystream bit history.
module tb_trivium_byte_xor;
   localparam int WARM = 1152;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic clear = 1'b0;
   logic ks_enable, ks_bit, busy;
   trivium_byte_xor_if bus ();
   trivium_byte_xor dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (start),
      .i_clear     (clear),
      .i_ks_bit    (ks_bit),
      .o_ks_enable (ks_enable),
      .o_busy      (busy),
      .bus         (bus)
   );
   always #5 clk = ~clk;
   int assertions = 0;
   int failures = 0;
   int cyc = 0;
   bit ks_bits[$];
   logic [7:0] exp_q[$];
   int out_times[$];
   int kidx = 0;
   bit force8 = 1'b1;
   logic [7:0] pat = 8'h8D;
   logic prev_stall = 1'b0;
   logic [7:0] prev_data = '0;
   function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
      assertions++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
      end
   endfunction
   function automatic logic [7:0] ks_byte(int k);
      logic [7:0] b = '0;
      for (int i = 0; i < 8; i++) b[i] = ks_bits[WARM + 8 * k + i];
      return b;
   endfunction
   always @(posedge clk) cyc <= cyc + 1;
   // Stand-in for the keystream core: one new registered bit per enable pulse.
   always @(posedge clk) begin : core
      logic b;
      if (ks_enable) begin
         if (force8 && ks_bits.size() >= WARM && ks_bits.size() < WARM + 8) b = pat[ks_bits.size() - WARM];
         else b = 1'($urandom);
         ks_bits.push_back(b);
         ks_bit <= b;
      end
   end
   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_ks_enable", ks_enable, 0);
         chk("rst_in_ready", bus.in_ready, 0);
         chk("rst_out_valid", bus.out_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_out_data", bus.out_data, 0);
         exp_q.delete();
         kidx = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_data", bus.out_data, prev_data);
         end
         if (bus.in_ready) begin
            chk("ready_no_enable", ks_enable, 0);
            chk("ready_backpressure", !bus.out_valid || bus.out_ready, 1);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
            else chk("out_data", bus.out_data, exp_q.pop_front());
            out_times.push_back(cyc);
         end
         if (bus.in_valid && bus.in_ready) begin
            if (ks_bits.size() < WARM + 8 * (kidx + 1)) chk("ks_bits_available", ks_bits.size(), WARM + 8 * (kidx + 1));
            else exp_q.push_back(bus.in_data ^ ks_byte(kidx));
            kidx++;
         end
         prev_stall = bus.out_valid && !bus.out_ready && !clear;
         prev_data = bus.out_data;
         if (clear) begin
            exp_q.delete();
            kidx = 0;
         end
      end
   end
   task automatic do_start();
      @(posedge clk); #1;
      if (!busy) begin
         ks_bits.delete();
         exp_q.delete();
         kidx = 0;
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask
   task automatic measure_warmup(input int poke);
      int n = 0;
      int rdy = 0;
      for (int i = 0; i < 1400; i++) begin
         @(negedge clk);
         start = (i == poke);
         if (bus.in_ready) rdy++;
         if (ks_enable) n++;
         else if (n > 0) break;
      end
      start = 1'b0;
      chk("warmup_fill_run", n, WARM + 8);
      chk("ready_before_fill", rdy, 0);
      chk("bits_at_fill_end", ks_bits.size(), WARM + 8);
      @(negedge clk);
      chk("ready_after_fill", bus.in_ready, 1);
   endtask
   task automatic accept_one(input logic [7:0] d);
      bit ok = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data = d;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask
   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk); #1;
      end
      chk("drain", exp_q.size(), 0);
   endtask
   task automatic pulse_clear();
      @(posedge clk); #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      @(negedge clk);
      chk("clear_busy", busy, 0);
      chk("clear_ks_enable", ks_enable, 0);
      chk("clear_out_valid", bus.out_valid, 0);
      chk("clear_in_ready", bus.in_ready, 0);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int n, en, rdy, n0;
      bit ok;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      // Warm-up length, fill length and the fixed first byte.
      do_start();
      measure_warmup(-1);
      chk("model_byte0", ks_byte(0), 8'h8D);
      accept_one(8'hFF);
      @(negedge clk);
      chk("lit_out_valid", bus.out_valid, 1);
      chk("lit_out_data", bus.out_data, 8'h72);
      force8 = 1'b0;
      // Back-pressure: one byte held, the next keystream byte filled, then everything stalls.
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      accept_one(8'($urandom));
      bus.in_valid = 1'b1;
      bus.in_data = 8'($urandom);
      en = 0;
      rdy = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (ks_enable) en++;
         if (bus.in_ready) rdy++;
      end
      chk("stall_fill_pulses", en, 8);
      chk("stall_no_ready", rdy, 0);
      chk("stall_enable_low", ks_enable, 0);
      chk("stall_out_held", bus.out_valid, 1);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("release_ready", ok, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      drain();
      // Streaming at full rate.
      n0 = out_times.size();
      for (int i = 0; i < 16; i++) accept_one(8'($urandom));
      drain();
      chk("stream_count", out_times.size() - n0, 16);
      for (int i = 1; i < 16; i++)
         if (n0 + i < out_times.size()) chk("stream_spacing", out_times[n0 + i] - out_times[n0 + i - 1], 10);
      // Abort during warm-up, then a complete restart.
      pulse_clear();
      do_start();
      n = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (ks_enable) n++;
         if (n == 500) break;
      end
      chk("warmup_500", n, 500);
      pulse_clear();
      do_start();
      measure_warmup(-1);
      accept_one(8'($urandom));
      drain();
      // Asynchronous reset mid-fill, then an ignored start while busy.
      accept_one(8'($urandom));
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ks_enable) n++;
         if (n == 4) break;
      end
      chk("fill_bit4", n, 4);
      #2 rst = 1'b0;
      #1;
      chk("async_ks_enable", ks_enable, 0);
      chk("async_busy", busy, 0);
      chk("async_in_ready", bus.in_ready, 0);
      chk("async_out_valid", bus.out_valid, 0);
      chk("async_out_data", bus.out_data, 0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      do_start();
      measure_warmup(100);
      accept_one(8'($urandom));
      accept_one(8'($urandom));
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end
endmodule
